// File: rtl/udma_hyper_pkg.sv
// Shared types for the hyperbus transaction scheduler: FSM state encoding and
// the channel-index width helper used by the arbiter and the top.
package udma_hyper_pkg;

  typedef enum logic [1:0] {
    SCH_IDLE,
    SCH_ISSUE,
    SCH_ACTIVE,
    SCH_RECOVER
  } sched_state_e;

  function automatic int id_width(input int nb_ch);
    return (nb_ch > 1) ? $clog2(nb_ch) : 1;
  endfunction

endpackage

// File: rtl/udma_hyper_rr_arb.sv
// Round-robin pick: first asserted request at or after ptr, wrapping at NB_CH.
// Purely combinational; no state, no backpressure of its own.
module udma_hyper_rr_arb
  import udma_hyper_pkg::*;
#(
  parameter  int NB_CH = 8,
  localparam int ID_W  = id_width(NB_CH)
) (
  input  logic [NB_CH-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [NB_CH-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             gnt_vld
);

  logic [ID_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = 0; k < NB_CH; k++) begin
      idx = ID_W'((32'(ptr) + 32'(k)) % NB_CH);
      if (!gnt_vld && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        gnt_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udma_hyper_trans_sched.sv
// Serialises uDMA channel descriptors onto one hyperbus PHY, one in flight, RR fair.
// Grant to phy_valid: 1 cycle; descriptor held until phy_ready; recovery gap after done.
module udma_hyper_trans_sched
  import udma_hyper_pkg::*;
#(
  parameter  int NB_CH      = 8,
  parameter  int TRANS_SIZE = 16,
  parameter  int ADDR_WIDTH = 32,
  localparam int ID_W       = id_width(NB_CH)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NB_CH-1:0]            req_valid_i,
  output logic [NB_CH-1:0]            req_ready_o,
  input  logic [NB_CH*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NB_CH*TRANS_SIZE-1:0] req_size_i,
  input  logic [NB_CH-1:0]            req_rwn_i,
  input  logic [31:0]                 cfg_t_read_write_recovery_i,
  output logic                        phy_valid_o,
  input  logic                        phy_ready_i,
  output logic [ADDR_WIDTH-1:0]       phy_addr_o,
  output logic [TRANS_SIZE-1:0]       phy_size_o,
  output logic                        phy_rwn_o,
  output logic [ID_W-1:0]             phy_id_o,
  input  logic                        phy_done_i,
  output logic [NB_CH-1:0]            busy_vec_o
);

  sched_state_e           state;
  logic [ID_W-1:0]        ptr;
  logic [ID_W-1:0]        ptr_nxt;
  logic [31:0]            rec_cnt;
  logic [NB_CH-1:0]       gnt;
  logic [ID_W-1:0]        gnt_idx;
  logic                   gnt_vld;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [TRANS_SIZE-1:0]  sel_size;
  logic                   sel_rwn;

  udma_hyper_rr_arb #(.NB_CH(NB_CH)) i_arb (
    .req     (req_valid_i),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Ready is only offered while idle and out of reset, so nothing is consumed that won't be latched.
  assign req_ready_o = (rst_ni && state == SCH_IDLE && gnt_vld) ? gnt : '0;
  assign ptr_nxt     = (gnt_idx == ID_W'(NB_CH - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    sel_addr = '0;
    sel_size = '0;
    sel_rwn  = 1'b0;
    for (int i = 0; i < NB_CH; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_size = req_size_i[i*TRANS_SIZE +: TRANS_SIZE];
        sel_rwn  = req_rwn_i[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= SCH_IDLE;
      ptr         <= '0;
      rec_cnt     <= '0;
      phy_valid_o <= 1'b0;
      phy_addr_o  <= '0;
      phy_size_o  <= '0;
      phy_rwn_o   <= 1'b0;
      phy_id_o    <= '0;
      busy_vec_o  <= '0;
    end else begin
      case (state)
        SCH_IDLE: begin
          if (gnt_vld) begin
            phy_addr_o  <= sel_addr;
            phy_size_o  <= sel_size;
            phy_rwn_o   <= sel_rwn;
            phy_id_o    <= gnt_idx;
            busy_vec_o  <= gnt;
            ptr         <= ptr_nxt;
            phy_valid_o <= 1'b1;
            state       <= SCH_ISSUE;
          end
        end
        SCH_ISSUE: begin
          if (phy_ready_i) begin
            phy_valid_o <= 1'b0;
            state       <= SCH_ACTIVE;
          end
        end
        SCH_ACTIVE: begin
          if (phy_done_i) begin
            busy_vec_o <= '0;
            if (cfg_t_read_write_recovery_i == 32'd0) begin
              state <= SCH_IDLE;
            end else begin
              rec_cnt <= cfg_t_read_write_recovery_i;
              state   <= SCH_RECOVER;
            end
          end
        end
        SCH_RECOVER: begin
          // The cycle that sees 1 is the last gap cycle, giving exactly cfg cycles here.
          rec_cnt <= rec_cnt - 32'd1;
          if (rec_cnt == 32'd1) state <= SCH_IDLE;
        end
        default: state <= SCH_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udma_hyper_trans_sched.sv
// Bench for udma_hyper_trans_sched: directed scenarios plus random traffic against a
// transaction-level model of bus ownership, presentation and recovery gap.
module tb_udma_hyper_trans_sched;

  localparam int NB = 4;
  localparam int AW = 32;
  localparam int SW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NB-1:0]     vld;
  logic [NB-1:0]     rdy;
  logic [NB*AW-1:0]  addr_f;
  logic [NB*SW-1:0]  size_f;
  logic [NB-1:0]     rwn;
  logic [31:0]       cfg;
  logic              phy_vld;
  logic              phy_rdy;
  logic [AW-1:0]     phy_addr;
  logic [SW-1:0]     phy_size;
  logic              phy_rwn;
  logic [1:0]        phy_id;
  logic              phy_done;
  logic [NB-1:0]     busy;

  logic [AW-1:0]     ch_addr [NB];
  logic [SW-1:0]     ch_size [NB];

  always_comb begin
    addr_f = '0;
    size_f = '0;
    for (int i = 0; i < NB; i++) begin
      addr_f[i*AW +: AW] = ch_addr[i];
      size_f[i*SW +: SW] = ch_size[i];
    end
  end

  udma_hyper_trans_sched #(.NB_CH(NB), .TRANS_SIZE(SW), .ADDR_WIDTH(AW)) dut (
    .clk_i                       (clk),
    .rst_ni                      (rst_n),
    .req_valid_i                 (vld),
    .req_ready_o                 (rdy),
    .req_addr_i                  (addr_f),
    .req_size_i                  (size_f),
    .req_rwn_i                   (rwn),
    .cfg_t_read_write_recovery_i (cfg),
    .phy_valid_o                 (phy_vld),
    .phy_ready_i                 (phy_rdy),
    .phy_addr_o                  (phy_addr),
    .phy_size_o                  (phy_size),
    .phy_rwn_o                   (phy_rwn),
    .phy_id_o                    (phy_id),
    .phy_done_i                  (phy_done),
    .busy_vec_o                  (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: who owns the bus, whether the descriptor is still being offered, gap cycles left.
  int            m_owner;
  int            m_rr;
  bit            m_pres;
  longint        m_gap;
  logic [AW-1:0] m_addr;
  logic [SW-1:0] m_size;
  logic          m_rwn;
  int            m_id;
  int            exp_w;
  logic [NB-1:0] exp_rdy;
  int            last_grant;
  int            exp_order [5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NB-1:0] v, input int start);
    for (int k = 0; k < NB; k++) begin
      if (((v >> ((start + k) % NB)) & 1) != 0) return (start + k) % NB;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NB-1:0] v);
    for (int i = 0; i < NB; i++) if (((v >> i) & 1) != 0) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_pres = 0; m_gap = 0;
    m_addr = '0; m_size = '0; m_rwn = 1'b0; m_id = 0;
  endtask

  task automatic sample();
    @(negedge clk);
    exp_w   = (rst_n && m_owner < 0 && m_gap == 0) ? rr_pick(vld, m_rr) : -1;
    exp_rdy = '0;
    if (exp_w >= 0) exp_rdy[exp_w] = 1'b1;
    chk("req_ready_o", rdy, exp_rdy);
    chk("phy_valid_o", phy_vld, m_pres);
    chk("busy_vec_o", busy, (m_owner >= 0) ? 64'(1 << m_owner) : 64'd0);
    chk("phy_addr_o", phy_addr, m_addr);
    chk("phy_size_o", phy_size, m_size);
    chk("phy_rwn_o", phy_rwn, m_rwn);
    chk("phy_id_o", phy_id, 64'(m_id));
    last_grant = exp_w;
  endtask

  task automatic adv();
    if (!rst_n) begin
      model_reset();
    end else if (exp_w >= 0) begin
      m_owner = exp_w; m_pres = 1; m_id = exp_w;
      m_addr = ch_addr[exp_w]; m_size = ch_size[exp_w]; m_rwn = rwn[exp_w];
      m_rr = (exp_w + 1) % NB;
    end else if (m_pres) begin
      if (phy_rdy) m_pres = 0;
    end else if (m_owner >= 0) begin
      if (phy_done) begin m_owner = -1; m_gap = longint'(cfg); end
    end else if (m_gap > 0) begin
      m_gap--;
    end
    @(posedge clk); #1;
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; vld = '0; phy_rdy = 1'b0; phy_done = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (m_owner >= 0 || m_gap > 0); i++) begin
      phy_rdy  = m_pres;
      phy_done = (m_owner >= 0 && !m_pres);
      cyc();
    end
    phy_rdy = 1'b0; phy_done = 1'b0;
  endtask

  // Leaves the bench after a sample with ready seen (caller advances), or after the budget.
  task automatic count_to_ready(output int k);
    int n;
    n = 0;
    while (n < 40) begin
      sample();
      if (rdy != '0) break;
      adv();
      n++;
    end
    k = n;
  endtask

  task automatic new_desc(input int i);
    ch_addr[i] = $urandom;
    ch_size[i] = 16'($urandom);
    rwn[i]     = 1'($urandom);
  endtask

  initial begin
    int k, ng, age, phase, prev_phase;
    rst_n = 1'b0; vld = '0; rwn = '0; cfg = 32'd0; phy_rdy = 1'b0; phy_done = 1'b0;
    for (int i = 0; i < NB; i++) begin ch_addr[i] = '0; ch_size[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;

    // Reset state
    sample();
    chk("rst_phy_valid", phy_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", phy_addr, 0);
    chk("rst_ready", rdy, 0);
    adv();

    // T1: single requester, recovery of 6
    cfg = 32'd6;
    ch_addr[2] = 32'h0000_1000; ch_size[2] = 16'd64; rwn[2] = 1'b1;
    vld = 4'b0100;
    sample(); chk("t1_ready_same_cycle", rdy, 4'b0100); adv();
    vld = '0; phy_rdy = 1'b1;
    sample();
    chk("t1_phy_valid", phy_vld, 1);
    chk("t1_id", phy_id, 2);
    chk("t1_addr", phy_addr, 32'h1000);
    chk("t1_size", phy_size, 64);
    chk("t1_rwn", phy_rwn, 1);
    chk("t1_busy", busy, 4'b0100);
    adv();
    phy_rdy = 1'b0;
    cyc(); cyc();
    phy_done = 1'b1; cyc(); phy_done = 1'b0;
    vld = 4'b0100;
    count_to_ready(k);
    chk("t1_recover_cycles", k, 6);
    adv();
    vld = '0;
    drain();

    // T2: all valid, no gap, round-robin order
    do_reset();
    cfg = 32'd0;
    for (int i = 0; i < NB; i++) new_desc(i);
    vld = '1; ng = 0; age = 0; prev_phase = 0;
    for (int c = 0; c < 300 && ng < 5; c++) begin
      phy_rdy  = m_pres && age >= 3;
      phy_done = (m_owner >= 0) && !m_pres && age >= 3;
      sample();
      if (rdy != '0) begin
        chk($sformatf("t2_grant%0d", ng), 64'(onehot_idx(rdy)), 64'(exp_order[ng]));
        ng++;
      end else if (phy_vld && ng > 0) begin
        chk("t2_busy_onehot", busy, 64'(1 << exp_order[ng-1]));
      end
      adv();
      phase = m_pres ? 1 : ((m_owner >= 0) ? 2 : 0);
      age = (phase == prev_phase) ? age + 1 : 0;
      prev_phase = phase;
    end
    chk("t2_grant_count", ng, 5);
    vld = '0;
    drain();

    // T3: ch1 waits behind ch3, then pointer follows ch1
    do_reset();
    cfg = 32'd3;
    new_desc(1); new_desc(3);
    vld = 4'b1000;
    sample(); chk("t3_ch3_ready", rdy, 4'b1000); adv();
    vld = 4'b0010; phy_rdy = 1'b1;
    sample(); chk("t3_ch1_wait_issue", rdy, 0); adv();
    phy_rdy = 1'b0;
    sample(); chk("t3_ch1_wait_active", rdy, 0); adv();
    phy_done = 1'b1;
    sample(); chk("t3_ch1_wait_done", rdy, 0); adv();
    phy_done = 1'b0;
    count_to_ready(k);
    chk("t3_recover_cycles", k, 3);
    chk("t3_ch1_granted", rdy, 4'b0010);
    adv();
    vld = '0;
    drain();
    vld = 4'b1101;
    sample(); chk("t3_ptr_is_2", rdy, 4'b0100); adv();
    vld = '0;
    drain();

    // T4: PHY stalls 10 cycles, done during ISSUE ignored
    do_reset();
    cfg = 32'd2;
    ch_addr[1] = 32'hCAFE_0040; ch_size[1] = 16'h0123; rwn[1] = 1'b0;
    vld = 4'b0010; cyc(); vld = '0; phy_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      phy_done = (i == 5);
      sample();
      chk("t4_valid_held", phy_vld, 1);
      chk("t4_addr_held", phy_addr, 32'hCAFE_0040);
      chk("t4_size_held", phy_size, 16'h0123);
      chk("t4_rwn_held", phy_rwn, 0);
      chk("t4_id_held", phy_id, 1);
      adv();
    end
    phy_done = 1'b0; phy_rdy = 1'b1; cyc(); phy_rdy = 1'b0;
    sample();
    chk("t4_done_ignored_busy", busy, 4'b0010);
    chk("t4_valid_dropped", phy_vld, 0);
    adv();
    drain();

    // T5: reset mid-ACTIVE and mid-RECOVER
    do_reset();
    cfg = 32'd4;
    ch_addr[1] = 32'h5555_0000; ch_size[1] = 16'h0040; rwn[1] = 1'b1;
    new_desc(0); new_desc(3);
    vld = 4'b0010; cyc(); vld = '0;
    phy_rdy = 1'b1; cyc(); phy_rdy = 1'b0; cyc();
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    vld = 4'b1001;
    sample();
    chk("t5a_valid", phy_vld, 0); chk("t5a_busy", busy, 0); chk("t5a_addr", phy_addr, 0);
    chk("t5a_size", phy_size, 0); chk("t5a_rwn", phy_rwn, 0); chk("t5a_id", phy_id, 0);
    chk("t5a_ptr0", rdy, 4'b0001);
    adv();
    vld = '0; drain();
    vld = 4'b0010; cyc(); vld = '0;
    phy_rdy = 1'b1; cyc(); phy_rdy = 1'b0;
    phy_done = 1'b1; cyc(); phy_done = 1'b0;
    cyc();
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    vld = 4'b1001;
    sample();
    chk("t5b_valid", phy_vld, 0); chk("t5b_busy", busy, 0); chk("t5b_addr", phy_addr, 0);
    chk("t5b_id", phy_id, 0);
    chk("t5b_ptr0", rdy, 4'b0001);
    adv();
    vld = '0; drain();

    // T6: gap fixed at load time; huge gap never exits early
    do_reset();
    cfg = 32'd5; new_desc(0);
    vld = 4'b0001; cyc(); vld = '0;
    phy_rdy = 1'b1; cyc(); phy_rdy = 1'b0;
    phy_done = 1'b1; cyc(); phy_done = 1'b0;
    cfg = 32'd1; vld = 4'b0001;
    count_to_ready(k);
    chk("t6_cfg_change_ignored", k, 5);
    adv();
    vld = '0; cfg = 32'hFFFF_FFFF;
    phy_rdy = 1'b1; cyc(); phy_rdy = 1'b0;
    phy_done = 1'b1; cyc(); phy_done = 1'b0;
    vld = 4'b0001;
    repeat (60) cyc();
    sample(); chk("t6_no_early_exit", rdy, 0); adv();
    force dut.rec_cnt = 32'd1;
    m_gap = 1;
    sample(); chk("t6_last_gap_cycle", rdy, 0); adv();
    release dut.rec_cnt;
    sample(); chk("t6_idle_after_1", rdy, 4'b0001); adv();
    vld = '0; cfg = 32'd2;
    drain();

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom % 250) != 0;
      if ($urandom % 50 == 0) cfg = $urandom_range(0, 4);
      for (int i = 0; i < NB; i++) begin
        if (vld[i] && last_grant == i) begin
          vld[i] = 1'($urandom);
          if (vld[i]) new_desc(i);
        end else if (vld[i]) begin
          if ($urandom % 30 == 0) vld[i] = 1'b0;
        end else if ($urandom % 4 == 0) begin
          vld[i] = 1'b1;
          new_desc(i);
        end
      end
      phy_rdy  = m_pres ? ($urandom % 3 == 0) : 1'($urandom);
      phy_done = (m_owner >= 0 && !m_pres) ? ($urandom % 4 == 0) : (m_pres && $urandom % 8 == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
